poly_mac_engine: RTL and testbench

//  Next-generation NLA polynomial MAC: evaluates y = sum c[k]*x^k by Horner's rule in signed fixed point.

---
 rtl/nla_pkg.sv | 35 +++
 rtl/nla_sync_fifo.sv | 73 +++++++
 rtl/poly_mac_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_poly_mac_engine.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nla_pkg.sv
// Shared types and helpers for the NLA polynomial MAC engine.
package nla_pkg;

    // Engine sequencer states; encodings are externally visible in debug and must not move.
    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        LOAD    = 3'b001,
        COMPUTE = 3'b010,
        STORE   = 3'b011
    } mac_state_t;

    // Working width of the clamp helper; wide enough for a full product plus carry at DATA_WIDTH<=64.
    localparam int SAT_W = 130;

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [SAT_W-1:0] sat_fx(
        input logic signed [SAT_W-1:0] val,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] one_v;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        one_v = {{(SAT_W-1){1'b0}}, 1'b1};
        max_v = (one_v <<< (width - 32'd1)) - one_v;
        min_v = ~max_v;
        if (val > max_v) begin
            sat_fx = max_v;
        end else if (val < min_v) begin
            sat_fx = min_v;
        end else begin
            sat_fx = val;
        end
    endfunction

endpackage

// File: rtl/nla_sync_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on rd_data_o while not empty.
module nla_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 5
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int DEPTH = 2 ** ADDR_LINES;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_LINES-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_LINES-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_LINES:0]   count_q, count_d;
    logic                  push_s;
    logic                  pop_s;

    // A pop in the same cycle never makes room for a write into a full FIFO.
    assign push_s    = wr_en_i & ~full_o;
    assign pop_s     = rd_en_i & ~empty_o;
    assign full_o    = (count_q == (ADDR_LINES+1)'(DEPTH));
    assign empty_o   = (count_q == {(ADDR_LINES+1){1'b0}});
    assign rd_data_o = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(ADDR_LINES-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(ADDR_LINES-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{ADDR_LINES{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{ADDR_LINES{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards any stored entries.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= {ADDR_LINES{1'b0}};
            rd_ptr_q <= {ADDR_LINES{1'b0}};
            count_q  <= {(ADDR_LINES+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/poly_mac_engine.sv
// Horner-rule polynomial evaluator in signed fixed point with buffered input and banked coefficients.
module poly_mac_engine
    import nla_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int ADDR_LINES = 5,
    parameter int MAX_TERMS  = 16,
    parameter int NUM_BANKS  = 2
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [DATA_WIDTH-1:0]          signal_i,
    input  logic                           wr_en_i,
    input  logic                           last_i,
    input  logic [$clog2(NUM_BANKS)-1:0]   bank_i,
    input  logic [$clog2(MAX_TERMS+1)-1:0] terms_i,
    input  logic                           coef_wr_en_i,
    input  logic [$clog2(NUM_BANKS)-1:0]   coef_bank_i,
    input  logic [$clog2(MAX_TERMS)-1:0]   coef_addr_i,
    input  logic [DATA_WIDTH-1:0]          coef_data_i,
    input  logic                           result_ready_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           idle_o,
    output logic                           wr_drop_o,
    output logic [DATA_WIDTH-1:0]          result_o,
    output logic                           result_valid_o,
    output logic                           result_last_o,
    output logic                           result_sat_o
);
    localparam int BANK_W  = $clog2(NUM_BANKS);
    localparam int TERMS_W = $clog2(MAX_TERMS + 1);
    localparam int IDX_W   = $clog2(MAX_TERMS);
    localparam int PAY_W   = DATA_WIDTH + BANK_W + 1;
    localparam int PROD_W  = 2 * DATA_WIDTH;
    localparam int SUM_W   = PROD_W + 1;

    // Input buffer: {last, bank, sample}
    logic [PAY_W-1:0]             fifo_wdata_s, fifo_rdata_s;
    logic                         fifo_full_s, fifo_empty_s, fifo_pop_s;
    logic signed [DATA_WIDTH-1:0] head_x_s;
    logic [BANK_W-1:0]            head_bank_s;
    logic                         head_last_s;

    assign fifo_wdata_s = {last_i, bank_i, signal_i};
    assign head_x_s     = fifo_rdata_s[DATA_WIDTH-1:0];
    assign head_bank_s  = fifo_rdata_s[DATA_WIDTH +: BANK_W];
    assign head_last_s  = fifo_rdata_s[PAY_W-1];

    nla_sync_fifo #(
        .DATA_WIDTH(PAY_W),
        .ADDR_LINES(ADDR_LINES)
    ) u_fifo (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .wr_en_i  (wr_en_i),
        .wr_data_i(fifo_wdata_s),
        .rd_en_i  (fifo_pop_s),
        .rd_data_o(fifo_rdata_s),
        .full_o   (fifo_full_s),
        .empty_o  (fifo_empty_s)
    );

    // Engine state
    mac_state_t                   state_q, state_d;
    logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] x_q, x_d;
    logic [BANK_W-1:0]            bank_q, bank_d;
    logic [IDX_W-1:0]             k_q, k_d;
    logic                         last_q, last_d;
    logic                         sat_q, sat_d;
    logic                         valid_q, valid_d;
    logic                         drop_q;

    // Coefficient storage and its single read port
    logic signed [DATA_WIDTH-1:0] coef_q [NUM_BANKS][MAX_TERMS];
    logic                         coef_wr_ok_s;
    logic [BANK_W-1:0]            rd_bank_s;
    logic [IDX_W-1:0]             rd_idx_s;
    logic signed [DATA_WIDTH-1:0] coef_rd_s;
    logic [TERMS_W-1:0]           t_s;

    // Horner step datapath
    logic signed [PROD_W-1:0]     prod_s, shift_s;
    logic signed [SUM_W-1:0]      sum_s;
    logic signed [SAT_W-1:0]      sat_full_s;
    logic signed [DATA_WIDTH-1:0] step_acc_s;
    logic                         step_sat_s;

    assign coef_wr_ok_s = coef_wr_en_i && (int'(coef_bank_i) < NUM_BANKS)
                          && (int'(coef_addr_i) < MAX_TERMS);
    assign t_s = (int'(terms_i) > MAX_TERMS) ? TERMS_W'(MAX_TERMS) : terms_i;

    // Coefficient banks; a write becomes visible to the datapath on the following cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < MAX_TERMS; i++) begin
                    coef_q[b][i] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else if (coef_wr_ok_s) begin
            coef_q[coef_bank_i][coef_addr_i] <= coef_data_i;
        end
    end

    // LOAD fetches the top coefficient of the head sample's bank; otherwise fetch c[k].
    always_comb begin
        rd_bank_s = bank_q;
        rd_idx_s  = k_q;
        coef_rd_s = {DATA_WIDTH{1'b0}};
        if (state_q == LOAD) begin
            rd_bank_s = head_bank_s;
            rd_idx_s  = IDX_W'(t_s - TERMS_W'(1));
        end else begin
            rd_bank_s = bank_q;
            rd_idx_s  = k_q;
        end
        if (int'(rd_bank_s) < NUM_BANKS) begin
            coef_rd_s = coef_q[rd_bank_s][rd_idx_s];
        end else begin
            coef_rd_s = {DATA_WIDTH{1'b0}};
        end
    end

    // One Horner step: full product, floor shift, wide add, clamp back to DATA_WIDTH.
    always_comb begin
        prod_s     = acc_q * x_q;
        shift_s    = prod_s >>> FRAC_BITS;
        sum_s      = SUM_W'(shift_s) + SUM_W'(coef_rd_s);
        sat_full_s = sat_fx(SAT_W'(sum_s), DATA_WIDTH);
        step_acc_s = sat_full_s[DATA_WIDTH-1:0];
        step_sat_s = (sat_full_s != SAT_W'(sum_s));
    end

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        x_d        = x_q;
        bank_d     = bank_q;
        k_d        = k_q;
        last_d     = last_q;
        sat_d      = sat_q;
        fifo_pop_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                fifo_pop_s = 1'b1;
                x_d        = head_x_s;
                bank_d     = head_bank_s;
                last_d     = head_last_s;
                sat_d      = 1'b0;
                k_d        = IDX_W'(t_s - TERMS_W'(2));
                if (t_s == {TERMS_W{1'b0}}) begin
                    acc_d   = {DATA_WIDTH{1'b0}};
                    state_d = STORE;
                end else if (t_s == TERMS_W'(1)) begin
                    acc_d   = coef_rd_s;
                    state_d = STORE;
                end else begin
                    acc_d   = coef_rd_s;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                acc_d = step_acc_s;
                sat_d = sat_q | step_sat_s;
                if (k_q == {IDX_W{1'b0}}) begin
                    state_d = STORE;
                end else begin
                    k_d     = k_q - IDX_W'(1);
                    state_d = COMPUTE;
                end
            end
            STORE: begin
                if (result_ready_i) begin
                    if (!fifo_empty_s) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = STORE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == STORE);
    end

    // Sequencer and datapath registers; reset aborts any in-flight sample.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            acc_q   <= {DATA_WIDTH{1'b0}};
            x_q     <= {DATA_WIDTH{1'b0}};
            bank_q  <= {BANK_W{1'b0}};
            k_q     <= {IDX_W{1'b0}};
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            bank_q  <= bank_d;
            k_q     <= k_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            drop_q  <= wr_en_i & fifo_full_s;
        end
    end

    assign full_o         = fifo_full_s;
    assign empty_o        = fifo_empty_s;
    assign idle_o         = (state_q == IDLE) & fifo_empty_s;
    assign wr_drop_o      = drop_q;
    assign result_o       = acc_q;
    assign result_valid_o = valid_q;
    assign result_last_o  = last_q;
    assign result_sat_o   = sat_q;

endmodule

// File: tb/tb_poly_mac_engine.sv
// Self-checking bench for poly_mac_engine with a plain-arithmetic polynomial reference.
module tb_poly_mac_engine;
    localparam int DW = 32;
    localparam int FB = 16;
    localparam int AL = 2;
    localparam int MT = 16;
    localparam int NB = 2;
    localparam longint MAXV = 64'sh7FFFFFFF;
    localparam longint MINV = -64'sh80000000;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic [DW-1:0] signal_i;
    logic          wr_en_i;
    logic          last_i;
    logic [0:0]    bank_i;
    logic [4:0]    terms_i;
    logic          coef_wr_en_i;
    logic [0:0]    coef_bank_i;
    logic [3:0]    coef_addr_i;
    logic [DW-1:0] coef_data_i;
    logic          result_ready_i;
    logic          full_o, empty_o, idle_o, wr_drop_o;
    logic [DW-1:0] result_o;
    logic          result_valid_o, result_last_o, result_sat_o;

    poly_mac_engine #(
        .DATA_WIDTH(DW), .FRAC_BITS(FB), .ADDR_LINES(AL), .MAX_TERMS(MT), .NUM_BANKS(NB)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .signal_i(signal_i), .wr_en_i(wr_en_i),
        .last_i(last_i), .bank_i(bank_i), .terms_i(terms_i),
        .coef_wr_en_i(coef_wr_en_i), .coef_bank_i(coef_bank_i), .coef_addr_i(coef_addr_i),
        .coef_data_i(coef_data_i), .result_ready_i(result_ready_i),
        .full_o(full_o), .empty_o(empty_o), .idle_o(idle_o), .wr_drop_o(wr_drop_o),
        .result_o(result_o), .result_valid_o(result_valid_o),
        .result_last_o(result_last_o), .result_sat_o(result_sat_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    longint model_c [NB][MT];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: y = sum c[k] x^k by Horner, each step clamped; returns {sat, y}.
    function automatic logic [32:0] model_eval(input logic [31:0] x, input int bank, input int terms);
        int t;
        longint acc, p, xl;
        logic signed [31:0] xs;
        logic s;
        t  = (terms > MT) ? MT : terms;
        s  = 1'b0;
        xs = x;
        xl = xs;
        if (t == 0) return 33'd0;
        acc = model_c[bank][t-1];
        for (int k = t - 2; k >= 0; k--) begin
            p = (acc * xl) >>> FB;
            p = p + model_c[bank][k];
            if (p > MAXV) begin p = MAXV; s = 1'b1; end
            else if (p < MINV) begin p = MINV; s = 1'b1; end
            acc = p;
        end
        return {s, acc[31:0]};
    endfunction

    task automatic write_coef(input int bank, input int addr, input logic [31:0] data);
        logic signed [31:0] ds;
        coef_bank_i  = 1'(bank);
        coef_addr_i  = 4'(addr);
        coef_data_i  = data;
        coef_wr_en_i = 1'b1;
        @(negedge clk_i);
        coef_wr_en_i = 1'b0;
        ds = data;
        model_c[bank][addr] = ds;
    endtask

    task automatic push(input logic [31:0] x, input int bank, input logic last);
        signal_i = x;
        bank_i   = 1'(bank);
        last_i   = last;
        wr_en_i  = 1'b1;
        @(negedge clk_i);
        wr_en_i  = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 1;
        while (result_valid_o !== 1'b1 && cyc < 400) begin
            @(negedge clk_i);
            cyc++;
        end
        check({tag, "_valid_seen"}, 64'(result_valid_o), 64'd1);
    endtask

    // Single sample through an idle engine: value, sat, last, latency, then handshake.
    task automatic run_single(input string tag, input logic [31:0] x, input int bank,
                              input logic last, input int terms,
                              output logic [31:0] res, output logic sat);
        logic [32:0] e;
        int cyc, t;
        t = (terms > MT) ? MT : terms;
        e = model_eval(x, bank, terms);
        terms_i = 5'(terms);
        push(x, bank, last);
        wait_valid(tag, cyc);
        check({tag, "_result"}, 64'(result_o), 64'(e[31:0]));
        check({tag, "_sat"}, 64'(result_sat_o), 64'(e[32]));
        check({tag, "_last"}, 64'(result_last_o), 64'(last));
        check({tag, "_latency"}, 64'(cyc), 64'(2 + ((t > 1) ? t : 1)));
        res = result_o;
        sat = result_sat_o;
        result_ready_i = 1'b1;
        @(negedge clk_i);
        result_ready_i = 1'b0;
        check({tag, "_valid_drop"}, 64'(result_valid_o), 64'd0);
    endtask

    logic [31:0] r, xv;
    logic        s;
    logic [32:0] expq [$];
    logic        lastq [$];
    int          cyc;

    initial begin
        rstn_i = 1'b0; signal_i = '0; wr_en_i = 1'b0; last_i = 1'b0; bank_i = '0;
        terms_i = '0; coef_wr_en_i = 1'b0; coef_bank_i = '0; coef_addr_i = '0;
        coef_data_i = '0; result_ready_i = 1'b0;
        for (int b = 0; b < NB; b++) for (int i = 0; i < MT; i++) model_c[b][i] = 0;
        repeat (3) @(negedge clk_i);
        check("rst_valid", 64'(result_valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_idle", 64'(idle_o), 64'd1);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_drop", 64'(wr_drop_o), 64'd0);
        check("rst_last", 64'(result_last_o), 64'd0);
        check("rst_sat", 64'(result_sat_o), 64'd0);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Horner example
        write_coef(0, 0, 32'h0001_0000);
        write_coef(0, 1, 32'h0001_0000);
        write_coef(0, 2, 32'h0000_8000);
        run_single("horner", 32'h0001_0000, 0, 1'b0, 3, r, s);
        check("horner_const", 64'(r), 64'h0002_8000);
        check("horner_sat_const", 64'(s), 64'd0);

        // Saturation example
        write_coef(1, 0, 32'h0000_0000);
        write_coef(1, 1, 32'h7FFF_0000);
        run_single("satur", 32'h0002_0000, 1, 1'b1, 2, r, s);
        check("satur_const", 64'(r), 64'h7FFF_FFFF);
        check("satur_sat_const", 64'(s), 64'd1);

        // Term-count boundaries
        run_single("t0", 32'h0001_0000, 0, 1'b0, 0, r, s);
        check("t0_const", 64'(r), 64'd0);
        run_single("t1", 32'h0003_0000, 0, 1'b1, 1, r, s);
        check("t1_const", 64'(r), 64'h0001_0000);
        for (int i = 3; i < MT; i++)
            write_coef(0, i, 32'(int'($urandom_range(0, 32'h3FFFF)) - 32'sh20000));
        run_single("t20", 32'h0000_8000, 0, 1'b0, 20, r, s);
        run_single("t16", 32'hFFFF_4000, 0, 1'b0, 16, r, s);

        // Randomized samples, mixing small values and full-range values
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (it % 3 == 0)
                    write_coef(int'($urandom_range(0, 1)), int'($urandom_range(0, MT-1)), $urandom);
                else
                    write_coef(int'($urandom_range(0, 1)), int'($urandom_range(0, MT-1)),
                               32'(int'($urandom_range(0, 32'h3FFFF)) - 32'sh20000));
            end
            if (it % 4 == 1) xv = $urandom;
            else xv = 32'(int'($urandom_range(0, 32'h3FFFF)) - 32'sh20000);
            run_single($sformatf("rnd%0d", it), xv, int'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 20)), r, s);
        end

        // Backpressure: one in the engine, four buffered, the sixth dropped
        terms_i = 5'd2;
        result_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            xv = 32'(int'($urandom_range(0, 32'h3FFFF)) - 32'sh20000);
            signal_i = xv;
            bank_i   = 1'b0;
            last_i   = (i >= 4);
            wr_en_i  = 1'b1;
            if (i < 5) begin
                expq.push_back(model_eval(xv, 0, 2));
                lastq.push_back(i == 4);
            end
            @(negedge clk_i);
            if (i == 4) begin
                check("bp_full", 64'(full_o), 64'd1);
                check("bp_nodrop", 64'(wr_drop_o), 64'd0);
            end
        end
        wr_en_i = 1'b0;
        check("bp_drop_pulse", 64'(wr_drop_o), 64'd1);
        @(negedge clk_i);
        check("bp_drop_clear", 64'(wr_drop_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_hold_valid%0d", i), 64'(result_valid_o), 64'd1);
            check($sformatf("bp_hold_result%0d", i), 64'(result_o), 64'(expq[0][31:0]));
            @(negedge clk_i);
        end
        result_ready_i = 1'b1;
        for (int j = 0; j < 5; j++) begin
            wait_valid($sformatf("bp%0d", j), cyc);
            check($sformatf("bp%0d_result", j), 64'(result_o), 64'(expq[j][31:0]));
            check($sformatf("bp%0d_last", j), 64'(result_last_o), 64'(lastq[j]));
            @(negedge clk_i);
        end
        result_ready_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("bp_no_extra", 64'(result_valid_o), 64'd0);
        check("bp_idle", 64'(idle_o), 64'd1);
        check("bp_empty", 64'(empty_o), 64'd1);

        // Asynchronous reset in the middle of a long evaluation with samples queued
        terms_i = 5'd16;
        push(32'h0000_C000, 0, 1'b0);
        push(32'h0001_0000, 0, 1'b0);
        push(32'h0001_0000, 1, 1'b1);
        repeat (4) @(negedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        check("arst_valid", 64'(result_valid_o), 64'd0);
        check("arst_idle", 64'(idle_o), 64'd1);
        check("arst_empty", 64'(empty_o), 64'd1);
        check("arst_full", 64'(full_o), 64'd0);
        check("arst_result", 64'(result_o), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int b = 0; b < NB; b++) for (int i = 0; i < MT; i++) model_c[b][i] = 0;
        @(negedge clk_i);
        run_single("post_rst_cleared", 32'h0001_0000, 0, 1'b0, 3, r, s);
        write_coef(1, 0, 32'h0003_0000);
        write_coef(1, 1, 32'h0001_0000);
        run_single("post_rst", 32'h0002_0000, 1, 1'b1, 2, r, s);
        check("post_rst_const", 64'(r), 64'h0005_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
